// File: rtl/audio_i2s_recorder.sv
// Left-channel I2S capture for the recorder's SRAM write path, clocked on the codec bit clock.
// Each 16-bit sample is written once with an auto-incrementing address; record/pause/stop FSM.
module audio_i2s_recorder #(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [15:0]       o_data,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_last_addr,
  output logic              o_recording,
  output logic              o_full
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StSkip,
    StCapture,
    StWrite,
    StPaused
  } state_e;

  state_e            state_q;
  logic              lrc_q;
  logic [14:0]       shift_q;
  logic [3:0]        bit_cnt_q;

  logic              lrc_fall;
  logic [15:0]       shift_next;
  logic [ADDR_W-1:0] prev_addr;
  logic              at_max;

  assign lrc_fall   = lrc_q & ~i_lrc;
  assign shift_next = {shift_q, i_data};
  // Address only advances on writes, so the last completed write sits one below it.
  assign prev_addr  = (o_address == '0) ? '0 : o_address - ADDR_W'(1);
  assign at_max     = (o_address == MAX_ADDR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      lrc_q       <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      o_address   <= '0;
      o_data      <= '0;
      o_wen       <= 1'b0;
      o_last_addr <= '0;
      o_recording <= 1'b0;
      o_full      <= 1'b0;
    end else begin
      lrc_q  <= i_lrc;
      o_wen  <= 1'b0;
      o_full <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_start) begin
            o_address   <= '0;
            o_recording <= 1'b1;
            state_q     <= StWait;
          end
        end
        StWait, StSkip, StCapture: begin
          if (i_stop) begin
            state_q     <= StIdle;
            o_recording <= 1'b0;
            o_last_addr <= prev_addr;
          end else if (i_pause) begin
            state_q     <= StPaused;
            o_recording <= 1'b0;
          end else if (state_q == StWait) begin
            if (lrc_fall) state_q <= StSkip;
          end else if (state_q == StSkip) begin
            state_q   <= StCapture;
            bit_cnt_q <= '0;
          end else begin
            shift_q   <= shift_next[14:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              state_q <= StWrite;
              o_wen   <= 1'b1;
              o_data  <= shift_next;
              o_full  <= at_max;
            end
          end
        end
        StWrite: begin
          if (at_max) begin
            state_q     <= StIdle;
            o_recording <= 1'b0;
            o_last_addr <= MAX_ADDR;
          end else begin
            o_address <= o_address + ADDR_W'(1);
            if (i_stop) begin
              state_q     <= StIdle;
              o_recording <= 1'b0;
              o_last_addr <= o_address;
            end else if (i_pause) begin
              state_q     <= StPaused;
              o_recording <= 1'b0;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StPaused: begin
          if (i_stop) begin
            state_q     <= StIdle;
            o_last_addr <= prev_addr;
          end else if (i_start) begin
            state_q     <= StWait;
            o_recording <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_i2s_recorder.sv
// Bench for audio_i2s_recorder: frame-level I2S stimulus with a write scoreboard per instance.
module tb_audio_i2s_recorder;

  logic        clk = 1'b0;
  logic        rst_n, lrc, sdata, start, pause, stop;
  logic [19:0] addr0, last0, addr1, last1;
  logic [15:0] data0, data1;
  logic        wen0, rec0, full0, wen1, rec1, full1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mon1_en = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic [19:0] addr;
    logic        full;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    int          addr;
  } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];
  vec_t vecs[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_i2s_recorder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdata),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_address(addr0), .o_data(data0), .o_wen(wen0), .o_last_addr(last0),
    .o_recording(rec0), .o_full(full0)
  );

  audio_i2s_recorder #(.ADDR_W(20), .MAX_ADDR(20'd3)) dut_max (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdata),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_address(addr1), .o_data(data1), .o_wen(wen1), .o_last_addr(last1),
    .o_recording(rec1), .o_full(full1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards: pop one expectation per observed write strobe.
  always @(negedge clk) begin
    exp_t e;
    if (wen0) begin
      if (sb0.size() == 0) begin
        check("dut_unexpected_wen", 1, 0);
      end else begin
        e = sb0.pop_front();
        check("dut_wen_data", {16'h0, data0}, {16'h0, e.data});
        check("dut_wen_addr", {12'h0, addr0}, {12'h0, e.addr});
        check("dut_wen_cycle", cyc, e.cyc);
        check("dut_wen_full", {31'h0, full0}, {31'h0, e.full});
      end
    end else if (full0) begin
      check("dut_full_without_wen", 1, 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon1_en && wen1) begin
      if (sb1.size() == 0) begin
        check("max_unexpected_wen", 1, 0);
      end else begin
        e = sb1.pop_front();
        check("max_wen_data", {16'h0, data1}, {16'h0, e.data});
        check("max_wen_addr", {12'h0, addr1}, {12'h0, e.addr});
        check("max_wen_cycle", cyc, e.cyc);
        check("max_wen_full", {31'h0, full1}, {31'h0, e.full});
      end
    end else if (mon1_en && full1) begin
      check("max_full_without_wen", 1, 0);
    end
  end

  task automatic pulse(input logic [2:0] ev);
    @(negedge clk);
    {start, pause, stop} = ev;
    @(negedge clk);
    {start, pause, stop} = 3'b000;
  endtask

  // One 40-cycle LRC frame, left half first; ev pulses {start,pause,stop} at cycle ev_k.
  task automatic frame(input logic [15:0] left, input logic [15:0] right, input int push0,
                       input int push1, input int ev_k, input logic [2:0] ev);
    exp_t e;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        e.data = left;
        e.cyc  = cyc + 18;
        if (push0 >= 0) begin
          e.addr = 20'(push0);
          e.full = 1'b0;
          sb0.push_back(e);
        end
        if (push1 >= 0) begin
          e.addr = 20'(push1);
          e.full = (push1 == 3);
          sb1.push_back(e);
        end
      end
      lrc = (k >= 20);
      if (k >= 2 && k <= 17) sdata = left[17-k];
      else if (k >= 22 && k <= 37) sdata = right[37-k];
      else sdata = 1'b0;
      {start, pause, stop} = (k == ev_k) ? ev : 3'b000;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"}, {12'h0, addr0}, 32'h0);
    check({tag, "_data"}, {16'h0, data0}, 32'h0);
    check({tag, "_wen"}, {31'h0, wen0}, 32'h0);
    check({tag, "_last_addr"}, {12'h0, last0}, 32'h0);
    check({tag, "_recording"}, {31'h0, rec0}, 32'h0);
    check({tag, "_full"}, {31'h0, full0}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{left: 16'hA5C3, right: 16'hFFFF, addr: 0};
    vecs[1] = '{left: 16'h0001, right: 16'hFFFF, addr: 1};
    vecs[2] = '{left: 16'h8000, right: 16'hFFFF, addr: 2};
    vecs[3] = '{left: 16'h1357, right: 16'hFFFF, addr: 0};
    vecs[4] = '{left: 16'hFFFE, right: 16'h0000, addr: 1};
    vecs[5] = '{left: 16'h7FFF, right: 16'hAAAA, addr: 2};
    vecs[6] = '{left: 16'h0F0F, right: 16'h5555, addr: 3};
    vecs[7] = '{left: 16'hC001, right: 16'hFFFF, addr: 4};

    rst_n = 1'b0; lrc = 1'b0; sdata = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Three left words, right channel all ones.
    pulse(3'b100);
    check("rec_after_start", {31'h0, rec0}, 32'h1);
    @(negedge clk); lrc = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) frame(vecs[i].left, vecs[i].right, vecs[i].addr, -1, -1, 3'b000);
    check("rec_while_running", {31'h0, rec0}, 32'h1);

    // Pause mid-capture discards the sample; resume writes at the held address.
    pulse(3'b001);
    check("stop_last_addr_2", {12'h0, last0}, 32'h2);
    check("rec_after_stop", {31'h0, rec0}, 32'h0);
    pulse(3'b100);
    frame(16'h1234, 16'hFFFF, 0, -1, -1, 3'b000);
    frame(16'h5678, 16'hFFFF, -1, -1, 10, 3'b010);
    check("rec_after_pause", {31'h0, rec0}, 32'h0);
    pulse(3'b100);
    check("rec_after_resume", {31'h0, rec0}, 32'h1);
    frame(16'hBEEF, 16'hFFFF, 1, -1, -1, 3'b000);

    // Five samples then stop; a fresh start restarts at address 0.
    pulse(3'b001);
    pulse(3'b100);
    for (int i = 3; i < 8; i++) frame(vecs[i].left, vecs[i].right, vecs[i].addr, -1, -1, 3'b000);
    pulse(3'b001);
    check("stop_last_addr_4", {12'h0, last0}, 32'h4);
    check("rec_idle_after_stop", {31'h0, rec0}, 32'h0);
    pulse(3'b100);
    frame(16'h0F0F, 16'hFFFF, 0, -1, -1, 3'b000);

    // All three pulses together in CAPTURE: stop wins, so next start writes at 0, not 1.
    frame(16'h3333, 16'hFFFF, -1, -1, 10, 3'b111);
    check("rec_after_triple", {31'h0, rec0}, 32'h0);
    check("triple_last_addr", {12'h0, last0}, 32'h0);
    frame(16'h4444, 16'hFFFF, -1, -1, -1, 3'b000);
    pulse(3'b010);
    pulse(3'b100);
    frame(16'h5555, 16'hFFFF, 0, -1, -1, 3'b000);
    // Stop sampled during the WRITE cycle: write completes and is counted.
    frame(16'h6666, 16'hFFFF, 1, -1, 18, 3'b001);
    check("stop_in_write_last_addr", {12'h0, last0}, 32'h1);
    check("rec_after_stop_in_write", {31'h0, rec0}, 32'h0);

    // MAX_ADDR=3 instance records until full.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    mon1_en = 1'b1;
    pulse(3'b100);
    for (int i = 0; i < 6; i++) begin
      frame(16'h1000 + 16'(i), 16'hFFFF, i, (i <= 3) ? i : -1, -1, 3'b000);
    end
    check("max_last_addr", {12'h0, last1}, 32'h3);
    check("max_rec_after_full", {31'h0, rec1}, 32'h0);
    mon1_en = 1'b0;

    // Asynchronous reset in the middle of CAPTURE.
    pulse(3'b001);
    pulse(3'b100);
    frame(16'h1111, 16'hFFFF, 0, -1, -1, 3'b000);
    frame(16'h2222, 16'hFFFF, 1, -1, -1, 3'b000);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lrc = (k >= 20);
      sdata = k[0];
      if (k == 10) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
      end
      if (k == 12) rst_n = 1'b1;
    end
    frame(16'h8888, 16'hFFFF, -1, -1, -1, 3'b000);
    check("no_wen_after_reset", {31'h0, wen0}, 32'h0);

    repeat (3) @(negedge clk);
    check("dut_pending_writes", sb0.size(), 0);
    check("max_pending_writes", sb1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
